obi_mem_responder: RTL and testbench

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

---
 rtl/obi_mem_responder.sv | 154 +++++++++++++++
 tb/tb_obi_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// Single-port OBI memory responder with configurable grant stall and response latency.
// Out-of-range accesses are absorbed: writes are dropped, reads return a marker word, and both are counted.

package obi_mem_responder_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module obi_mem_responder
    import obi_mem_responder_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned GNT_WAIT     = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  slave_req_i,
    output obi_resp_t slave_resp_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned AW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [32:0] SPAN     = 33'(NUM_WORDS) << 2;
    localparam logic [2:0]  CNT_LAST = 3'((GNT_WAIT > 0) ? GNT_WAIT - 1 : 0);
    localparam logic [31:0] OOR_DATA = 32'hBADC_AB1E;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;

    logic        gnt;
    logic        accept;
    logic        in_range;
    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic [31:0] entry_data;

    logic [31:0] mem_q [NUM_WORDS];
    logic        vld_q [RESP_LATENCY];
    logic [31:0] dat_q [RESP_LATENCY];
    logic [7:0]  err_q;

    // Grant is combinational on req so zero-wait operation sustains one accept per cycle.
    always_comb begin
        gnt = 1'b0;
        if (!rst_i) begin
            if (GNT_WAIT == 0) begin
                gnt = slave_req_i.req;
            end else begin
                gnt = slave_req_i.req && (state_q == WAIT) && (cnt_q == CNT_LAST);
            end
        end
    end

    assign accept   = slave_req_i.req && gnt;
    assign offset   = slave_req_i.addr - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign word_idx = offset[AW+1:2];

    always_comb begin
        entry_data = '0;
        if (accept && !slave_req_i.we) begin
            entry_data = in_range ? mem_q[word_idx] : OOR_DATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (GNT_WAIT != 0 && slave_req_i.req) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (!slave_req_i.req || cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
            endcase
        end
    end

    // Storage is intentionally left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (accept && in_range && slave_req_i.we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (slave_req_i.be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            dat_q[0] <= entry_data;
            for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else if (accept && !in_range && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    always_comb begin
        slave_resp_o        = '0;
        slave_resp_o.gnt    = gnt;
        slave_resp_o.rvalid = vld_q[RESP_LATENCY-1];
        slave_resp_o.rdata  = dat_q[RESP_LATENCY-1];
    end

    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: four configurations run side by side, each checked every cycle
// against a transaction-level model (word array, error tally, queue of due responses).

module tb_obi_mem_responder;
    import obi_mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : gb
        localparam int unsigned GW   = (g == 1) ? 3 : 0;
        localparam int unsigned L    = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 3;
        localparam int unsigned NW   = 16;
        localparam logic [31:0] BASE = 32'h0000_1000 * (g + 1);

        logic      rst = 1'b1;
        obi_req_t  req;
        obi_resp_t resp;
        logic [7:0] err;
        logic      done = 1'b0;

        obi_mem_responder #(
            .NUM_WORDS   (NW),
            .BASE_ADDR   (BASE),
            .GNT_WAIT    (GW),
            .RESP_LATENCY(L)
        ) dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .slave_req_i (req),
            .slave_resp_o(resp),
            .err_cnt_o   (err)
        );

        logic [31:0] mmem [NW];
        int          merr  = 0;
        int          stall = 0;
        int          due_q [$];
        logic [31:0] rsp_q [$];
        int          cyc = 0;
        int          acc_cyc = 0;
        int          last_rv_cyc = 0;
        logic [31:0] last_rd = '0;

        // One clock cycle: drive at the falling edge, check outputs, then advance the model.
        task automatic step(input logic r, input logic q, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
            logic        exp_gnt, exp_rv;
            logic [31:0] exp_rd, off, mask, rd;
            int          idx;
            @(negedge clk);
            cyc++;
            rst = r;
            req.req = q; req.we = w; req.be = b; req.addr = a; req.wdata = d;
            #1;
            exp_rv = 1'b0;
            exp_rd = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_rv = 1'b1;
                exp_rd = rsp_q[0];
                void'(due_q.pop_front());
                void'(rsp_q.pop_front());
            end
            exp_gnt = !r && q && (stall == int'(GW));
            check($sformatf("g%0d.gnt@%0d", g, cyc), {31'b0, resp.gnt}, {31'b0, exp_gnt});
            check($sformatf("g%0d.rvalid@%0d", g, cyc), {31'b0, resp.rvalid}, {31'b0, exp_rv});
            check($sformatf("g%0d.rdata@%0d", g, cyc), resp.rdata, exp_rd);
            check($sformatf("g%0d.err@%0d", g, cyc), {24'b0, err}, 32'(merr));
            if (resp.rvalid) begin
                last_rd     = resp.rdata;
                last_rv_cyc = cyc;
            end
            if (exp_gnt) begin
                acc_cyc = cyc;
                off = a - BASE;
                rd  = '0;
                if (off < 4 * NW) begin
                    idx = int'(off / 4);
                    if (w) begin
                        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
                        mmem[idx] = (mmem[idx] & ~mask) | (d & mask);
                    end else begin
                        rd = mmem[idx];
                    end
                end else begin
                    if (merr < 255) merr++;
                    if (!w) rd = 32'hBADC_AB1E;
                end
                due_q.push_back(cyc + int'(L));
                rsp_q.push_back(rd);
            end
            if (r) begin
                stall = 0;
                merr  = 0;
                due_q.delete();
                rsp_q.delete();
            end else if (exp_gnt || !q) begin
                stall = 0;
            end else begin
                stall++;
            end
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
        endtask

        task automatic xfer(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
            int   waited = 0;
            logic got    = 1'b0;
            for (int n = 0; n < 12 && !got; n++) begin
                step(1'b0, 1'b1, w, b, a, d);
                if (resp.gnt) got = 1'b1;
                else waited++;
            end
            check($sformatf("g%0d.gnt_seen", g), {31'b0, got}, 32'd1);
            check($sformatf("g%0d.gnt_wait", g), 32'(waited), 32'(GW));
        endtask

        initial begin
            req = '0;
            step(1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
            step(1'b1, 1'b1, 1'b0, 4'h0, BASE, '0);
            check($sformatf("g%0d.rst_err", g), {24'b0, err}, 32'd0);
            idle(1);

            for (int i = 0; i < int'(NW); i++) xfer(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);

            xfer(1'b1, 4'hF, BASE + 32'd8, 32'h1234_5678);
            xfer(1'b0, 4'h0, BASE + 32'd8, '0);
            idle(int'(L) + 1);
            check($sformatf("g%0d.wr_rd", g), last_rd, 32'h1234_5678);
            check($sformatf("g%0d.rd_lat", g), 32'(last_rv_cyc - acc_cyc), 32'(L));

            xfer(1'b1, 4'b0010, BASE + 32'd8, 32'hAABB_CCDD);
            xfer(1'b0, 4'h0, BASE + 32'd10, '0);
            idle(int'(L) + 1);
            check($sformatf("g%0d.partial", g), last_rd, 32'h1234_CC78);

            step(1'b0, 1'b1, 1'b0, 4'h0, BASE, '0);
            idle(int'(L) + 3);

            for (int i = 0; i < 4; i++) xfer(1'b0, 4'h0, BASE + 32'(4 * i), '0);
            idle(int'(L) + 1);
            check($sformatf("g%0d.burst_last", g), last_rd, mmem[3]);
            check($sformatf("g%0d.burst_lat", g), 32'(last_rv_cyc - acc_cyc), 32'(L));

            xfer(1'b0, 4'h0, BASE, '0);
            xfer(1'b0, 4'h0, BASE + 32'd4, '0);
            step(1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
            idle(int'(L) + 2);
            xfer(1'b0, 4'h0, BASE + 32'd8, '0);
            idle(int'(L) + 1);
            check($sformatf("g%0d.post_rst_rd", g), last_rd, 32'h1234_CC78);

            check($sformatf("g%0d.err_zero", g), {24'b0, err}, 32'd0);
            xfer(1'b0, 4'h0, BASE + 32'(4 * NW), '0);
            idle(int'(L) + 1);
            check($sformatf("g%0d.oor_rd", g), last_rd, 32'hBADC_AB1E);
            check($sformatf("g%0d.err_one", g), {24'b0, err}, 32'd1);
            for (int i = 0; i < 300; i++) begin
                case (i % 3)
                    0:       xfer(i[0], 4'hF, BASE + 32'(4 * NW), $urandom);
                    1:       xfer(i[0], 4'hF, BASE - 32'd4, $urandom);
                    default: xfer(i[0], 4'hF, BASE + 32'(4 * NW) + 32'($urandom_range(0, 255)) * 4, $urandom);
                endcase
            end
            idle(int'(L) + 1);
            check($sformatf("g%0d.err_sat", g), {24'b0, err}, 32'hFF);
            xfer(1'b0, 4'h0, BASE + 32'd8, '0);
            idle(int'(L) + 1);
            check($sformatf("g%0d.oor_nowrite", g), last_rd, 32'h1234_CC78);

            for (int i = 0; i < 400; i++) begin
                logic [31:0] a;
                if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, 4 * NW + 15));
                else a = $urandom;
                step($urandom_range(0, 63) == 0, $urandom_range(0, 19) < 17, 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), a, $urandom);
            end
            idle(int'(L) + 2);
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 90000; t++) begin
            @(posedge clk);
            if (gb[0].done && gb[1].done && gb[2].done && gb[3].done) break;
        end
        check("all_done", {28'b0, gb[3].done, gb[2].done, gb[1].done, gb[0].done}, 32'hF);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
